// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter sharing one allocator LSU channel between several requester FSMs,
// with one transaction in flight and free-list lock ownership enforced across LOCK/UNLOCK.
package falafel_lsu_pkg;
    typedef enum logic [2:0] {
        OP_LOAD,
        OP_UPDATE,
        OP_ALLOC_INSERT,
        OP_FREE_INSERT,
        OP_DELETE,
        OP_LOCK,
        OP_UNLOCK
    } lsu_op_e;

    typedef struct packed {
        logic        val;
        lsu_op_e     op;
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next;
        logic [28:0] meta;
    } header_data_req_t;

    typedef struct packed {
        logic        val;
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next;
    } header_data_rsp_t;
endpackage

module falafel_lsu_arbiter
    import falafel_lsu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  header_data_req_t [NUM_REQ-1:0]      req_i,
    output logic             [NUM_REQ-1:0]      req_ready_o,
    output header_data_rsp_t [NUM_REQ-1:0]      rsp_o,
    output header_data_req_t                    lsu_req_o,
    input  logic                                lsu_req_ready_i,
    input  header_data_rsp_t                    lsu_rsp_i,
    output logic                                locked_o,
    output logic             [IDX_W-1:0]        lock_owner_o,
    output logic                                busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_e;

    state_e                          state;
    logic             [IDX_W-1:0]    rr_ptr;
    logic                            locked;
    logic             [IDX_W-1:0]    owner;
    logic             [IDX_W-1:0]    grant_q;
    lsu_op_e                         cap_op;
    header_data_req_t                lsu_req_q;
    header_data_rsp_t [NUM_REQ-1:0]  rsp_q;

    logic             [NUM_REQ-1:0]  cand;
    logic                            grant_found;
    logic             [IDX_W-1:0]    grant_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // While the lock is held only the owner may compete for the channel.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = req_i[i].val && (!locked || (owner == IDX_W'(i)));
        end
    end

    // Descending scan so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && (state == IDLE) && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            locked    <= 1'b0;
            owner     <= '0;
            grant_q   <= '0;
            cap_op    <= OP_LOAD;
            lsu_req_q <= '0;
            rsp_q     <= '0;
        end else begin
            rsp_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_q       <= grant_idx;
                        cap_op        <= req_i[grant_idx].op;
                        lsu_req_q     <= req_i[grant_idx];
                        lsu_req_q.val <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lsu_req_ready_i) begin
                        lsu_req_q <= '0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (lsu_rsp_i.val) begin
                        rsp_q[grant_q] <= lsu_rsp_i;
                        rr_ptr         <= wrap_idx(grant_q, 1);
                        // A stray UNLOCK from a non-owner is forwarded but must not drop someone else's lock.
                        if (cap_op == OP_LOCK) begin
                            locked <= 1'b1;
                            owner  <= grant_q;
                        end else if ((cap_op == OP_UNLOCK) && locked && (grant_q == owner)) begin
                            locked <= 1'b0;
                            owner  <= '0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu_req_o    = lsu_req_q;
    assign rsp_o        = rsp_q;
    assign locked_o     = locked;
    assign lock_owner_o = owner;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Self-checking bench for falafel_lsu_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level reference of the arbitration rules.
module tb_falafel_lsu_arbiter;
    import falafel_lsu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int IDX_W   = 1;

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    header_data_req_t [NUM_REQ-1:0]  req_i;
    logic             [NUM_REQ-1:0]  req_ready_o;
    header_data_rsp_t [NUM_REQ-1:0]  rsp_o;
    header_data_req_t                lsu_req_o;
    logic                            lsu_req_ready_i;
    header_data_rsp_t                lsu_rsp_i;
    logic                            locked_o;
    logic             [IDX_W-1:0]    lock_owner_o;
    logic                            busy_o;

    always #5 clk_i = ~clk_i;

    falafel_lsu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .req_ready_o     (req_ready_o),
        .rsp_o           (rsp_o),
        .lsu_req_o       (lsu_req_o),
        .lsu_req_ready_i (lsu_req_ready_i),
        .lsu_rsp_i       (lsu_rsp_i),
        .locked_o        (locked_o),
        .lock_owner_o    (lock_owner_o),
        .busy_o          (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference: one outstanding transaction record plus the round-robin pointer and lock.
    bit                              m_have, m_acc, m_locked;
    int                              m_g, m_rr, m_owner;
    header_data_req_t                m_txn;
    header_data_rsp_t [NUM_REQ-1:0]  m_rsp;
    bit                              granted_now, accepted_now;

    // Stimulus agents.
    bit          rand_en = 1'b0, lat_rand = 1'b0, spur_en = 1'b0;
    int          rdy_mode = 1, lat_fix = 0, cd = 0;
    bit          cd_active = 1'b0;
    logic [63:0] rsp_addr, size_fix, next_fix;
    int          lockseq [NUM_REQ];
    int          obs_grants [$];

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic header_data_req_t make_req(input lsu_op_e op, input logic [63:0] addr);
        header_data_req_t r;
        r.val  = 1'b1;
        r.op   = op;
        r.addr = addr;
        r.size = rand64();
        r.next = rand64();
        r.meta = 29'($urandom);
        return r;
    endfunction

    function automatic int predict_grant();
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (m_rr + k) % NUM_REQ;
            if (req_i[c].val && (!m_locked || c == m_owner)) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        granted_now  = 1'b0;
        accepted_now = 1'b0;
        if (!rst_ni) begin
            m_have = 1'b0; m_acc = 1'b0; m_rr = 0; m_locked = 1'b0; m_owner = 0; m_rsp = '0;
        end else begin
            m_rsp = '0;
            if (m_have && m_acc) begin
                if (lsu_rsp_i.val) begin
                    m_rsp[m_g] = lsu_rsp_i;
                    m_rr = (m_g + 1) % NUM_REQ;
                    if (m_txn.op == OP_LOCK) begin
                        m_locked = 1'b1; m_owner = m_g;
                    end else if (m_txn.op == OP_UNLOCK && m_locked && m_g == m_owner) begin
                        m_locked = 1'b0; m_owner = 0;
                    end
                    m_have = 1'b0;
                end
            end else if (m_have) begin
                if (lsu_req_ready_i) begin
                    m_acc = 1'b1; accepted_now = 1'b1;
                end
            end else begin
                g = predict_grant();
                if (g >= 0) begin
                    m_have = 1'b1; m_acc = 1'b0; m_g = g; m_txn = req_i[g]; granted_now = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int               g;
        logic [NUM_REQ-1:0] exp_ready;
        header_data_req_t exp_lsu;
        g = predict_grant();
        exp_ready = '0;
        if (rst_ni && !m_have && g >= 0) exp_ready[g] = 1'b1;
        exp_lsu = '0;
        if (m_have && !m_acc) begin
            exp_lsu = m_txn;
            exp_lsu.val = 1'b1;
        end
        checkOutput("req_ready", 512'(req_ready_o), 512'(exp_ready));
        checkOutput("lsu_req", 512'(lsu_req_o), 512'(exp_lsu));
        for (int i = 0; i < NUM_REQ; i++) checkOutput("rsp", 512'(rsp_o[i]), 512'(m_rsp[i]));
        checkOutput("locked", 512'(locked_o), 512'(m_locked));
        checkOutput("lock_owner", 512'(lock_owner_o), 512'(m_owner));
        checkOutput("busy", 512'(busy_o), 512'(m_have));
        for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) obs_grants.push_back(i);
    endtask

    task automatic next_req(input int i, output header_data_req_t r);
        lsu_op_e op;
        int      roll;
        if (lockseq[i] > 0) begin
            lockseq[i]--;
            op = lsu_op_e'($urandom_range(0, 4));
        end else if (lockseq[i] == 0) begin
            lockseq[i] = -1;
            op = OP_UNLOCK;
        end else begin
            roll = $urandom_range(0, 99);
            if (roll < 8)       op = OP_LOCK;
            else if (roll < 13) op = OP_UNLOCK;
            else                op = lsu_op_e'($urandom_range(0, 4));
        end
        r = make_req(op, rand64());
    endtask

    task automatic drive_agents();
        header_data_req_t r;
        lsu_req_ready_i = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        lsu_rsp_i = '0;
        if (accepted_now) begin
            cd_active = 1'b1;
            cd = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
            rsp_addr = m_txn.addr;
        end
        if (cd_active) begin
            if (cd == 0) begin
                lsu_rsp_i.val  = 1'b1;
                lsu_rsp_i.addr = rsp_addr;
                lsu_rsp_i.size = rand_en ? rand64() : size_fix;
                lsu_rsp_i.next = rand_en ? rand64() : next_fix;
                cd_active = 1'b0;
            end else begin
                cd--;
            end
        end else if (spur_en && (!m_have || !m_acc) && $urandom_range(0, 9) == 0) begin
            lsu_rsp_i = {1'b1, rand64(), rand64(), rand64()};
        end
        if (rand_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted_now && m_g == i) begin
                    if (m_txn.op == OP_LOCK) lockseq[i] = $urandom_range(0, 2);
                    if (lockseq[i] >= 0 || $urandom_range(0, 2) != 0) begin
                        next_req(i, r);
                        req_i[i] = r;
                    end else begin
                        req_i[i] = '0;
                    end
                end else if (!req_i[i].val && $urandom_range(0, 2) == 0) begin
                    next_req(i, r);
                    req_i[i] = r;
                end
            end
        end
    endtask

    // One cycle: check at the falling edge, advance the reference at the rising edge, then drive.
    task automatic applyStimulus();
        @(negedge clk_i);
        if (chk_en) compare_all();
        @(posedge clk_i);
        model_step();
        #1;
        drive_agents();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        applyStimulus();
        rst_ni = 1'b1;
    endtask

    task automatic wait_rsp(input int i);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            applyStimulus();
            if (rsp_o[i].val) seen = 1'b1;
        end
        checkOutput("rsp_arrive", 512'(seen), 512'(1));
    endtask

    task automatic owner_op(input lsu_op_e op);
        req_i[1] = make_req(op, rand64());
        applyStimulus();
        req_i[1] = '0;
        wait_rsp(1);
    endtask

    initial begin
        header_data_req_t held;
        int exp_rr [4]   = '{0, 1, 0, 1};
        int exp_lock [5] = '{1, 1, 1, 1, 0};

        for (int i = 0; i < NUM_REQ; i++) lockseq[i] = -1;
        rst_ni = 1'b0;
        req_i = '0;
        lsu_req_ready_i = 1'b0;
        lsu_rsp_i = '0;
        size_fix = 64'h40;
        next_fix = 64'h200;
        applyStimulus();
        rst_ni = 1'b1;
        chk_en = 1'b1;
        checkOutput("reset_lsu_req", 512'(lsu_req_o), 512'(0));
        checkOutput("reset_rsp", 512'(rsp_o), 512'(0));
        checkOutput("reset_locked", 512'(locked_o), 512'(0));
        checkOutput("reset_busy", 512'(busy_o), 512'(0));

        // Single requester, best-case latency.
        req_i[0] = make_req(OP_LOAD, 64'h100);
        applyStimulus();
        req_i[0] = '0;
        checkOutput("t1_lsu_val", 512'(lsu_req_o.val), 512'(1));
        checkOutput("t1_lsu_addr", 512'(lsu_req_o.addr), 512'(64'h100));
        applyStimulus();
        applyStimulus();
        checkOutput("t3_rsp_val", 512'(rsp_o[0].val), 512'(1));
        checkOutput("t3_rsp_addr", 512'(rsp_o[0].addr), 512'(64'h100));
        checkOutput("t3_rsp_size", 512'(rsp_o[0].size), 512'(64'h40));
        checkOutput("t3_rsp_next", 512'(rsp_o[0].next), 512'(64'h200));
        checkOutput("t3_rsp1_val", 512'(rsp_o[1].val), 512'(0));

        // Round-robin with both requesters asserting continuously.
        do_reset();
        obs_grants.delete();
        req_i[0] = make_req(OP_LOAD, 64'h1000);
        req_i[1] = make_req(OP_LOAD, 64'h2000);
        repeat (12) applyStimulus();
        req_i = '0;
        checkOutput("rr_count", 512'(obs_grants.size()), 512'(4));
        for (int k = 0; k < 4; k++)
            checkOutput("rr_order", 512'((k < obs_grants.size()) ? obs_grants[k] : -1), 512'(exp_rr[k]));
        applyStimulus();

        // Lock ownership: requester 0 waits out requester 1's locked sequence.
        do_reset();
        obs_grants.delete();
        req_i[1] = make_req(OP_LOCK, 64'h3000);
        applyStimulus();
        req_i[1] = '0;
        req_i[0] = make_req(OP_LOAD, 64'h4000);
        wait_rsp(1);
        checkOutput("lock_set", 512'(locked_o), 512'(1));
        checkOutput("lock_owner_set", 512'(lock_owner_o), 512'(1));
        owner_op(OP_LOAD);
        owner_op(OP_UPDATE);
        owner_op(OP_UNLOCK);
        checkOutput("lock_clear", 512'(locked_o), 512'(0));
        applyStimulus();
        req_i[0] = '0;
        checkOutput("lock_grant_count", 512'(obs_grants.size()), 512'(5));
        for (int k = 0; k < 5; k++)
            checkOutput("lock_order", 512'((k < obs_grants.size()) ? obs_grants[k] : -1), 512'(exp_lock[k]));
        wait_rsp(0);

        // LSU backpressure holds the request stable and blocks further grants.
        obs_grants.delete();
        rdy_mode = 2;
        lsu_req_ready_i = 1'b0;
        held = make_req(OP_DELETE, 64'h5000);
        req_i[0] = held;
        applyStimulus();
        req_i[0] = '0;
        req_i[1] = make_req(OP_LOAD, 64'h6000);
        repeat (5) begin
            applyStimulus();
            checkOutput("bp_lsu_req", 512'(lsu_req_o), 512'(held));
            checkOutput("bp_busy", 512'(busy_o), 512'(1));
        end
        checkOutput("bp_grants", 512'(obs_grants.size()), 512'(1));
        rdy_mode = 1;
        lsu_req_ready_i = 1'b1;
        wait_rsp(0);
        applyStimulus();
        req_i[1] = '0;
        wait_rsp(1);

        // Spurious LSU response in IDLE, then UNLOCK while unlocked.
        lsu_rsp_i = {1'b1, rand64(), rand64(), rand64()};
        applyStimulus();
        checkOutput("spur_rsp", 512'(rsp_o), 512'(0));
        checkOutput("spur_busy", 512'(busy_o), 512'(0));
        req_i[0] = make_req(OP_UNLOCK, 64'h7000);
        applyStimulus();
        req_i[0] = '0;
        wait_rsp(0);
        checkOutput("unlock_unlocked", 512'(locked_o), 512'(0));

        // Reset while waiting on the LSU with the lock held; the late response must vanish.
        req_i[1] = make_req(OP_LOCK, 64'h8000);
        applyStimulus();
        req_i[1] = '0;
        wait_rsp(1);
        checkOutput("mid_locked", 512'(locked_o), 512'(1));
        lat_fix = 3;
        req_i[1] = make_req(OP_LOAD, 64'h9000);
        applyStimulus();
        req_i[1] = '0;
        applyStimulus();
        checkOutput("mid_busy", 512'(busy_o), 512'(1));
        do_reset();
        checkOutput("post_rst_locked", 512'(locked_o), 512'(0));
        checkOutput("post_rst_busy", 512'(busy_o), 512'(0));
        checkOutput("post_rst_lsu", 512'(lsu_req_o), 512'(0));
        repeat (4) begin
            applyStimulus();
            checkOutput("post_rst_rsp", 512'(rsp_o), 512'(0));
        end
        lat_fix = 0;
        req_i[1] = make_req(OP_LOAD, 64'hA000);
        applyStimulus();
        req_i[1] = '0;
        wait_rsp(1);
        checkOutput("fresh_addr", 512'(rsp_o[1].addr), 512'(64'hA000));

        // Randomized traffic with random backpressure, latency and stray responses.
        do_reset();
        rand_en  = 1'b1;
        rdy_mode = 0;
        lat_rand = 1'b1;
        spur_en  = 1'b1;
        repeat (3000) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
